// File: rtl/e203_exu_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer driving the shared ALU adder and
// the two 33-bit shared state buffers that live in the datapath.
module e203_exu_muldiv_seq #(
  parameter int XLEN    = 32,
  parameter int ADDER_W = 35
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [2:0]         i_op,
  input  logic [XLEN-1:0]    i_rs1,
  input  logic [XLEN-1:0]    i_rs2,
  input  logic               flush,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [XLEN-1:0]    o_wbck_wdat,
  output logic               busy,
  output logic               muldiv_req_alu,
  output logic [ADDER_W-1:0] muldiv_req_alu_op1,
  output logic [ADDER_W-1:0] muldiv_req_alu_op2,
  output logic               muldiv_req_alu_add,
  output logic               muldiv_req_alu_sub,
  input  logic [ADDER_W-1:0] muldiv_req_alu_res,
  output logic               muldiv_sbf_0_ena,
  output logic [XLEN:0]      muldiv_sbf_0_nxt,
  input  logic [XLEN:0]      muldiv_sbf_0_r,
  output logic               muldiv_sbf_1_ena,
  output logic [XLEN:0]      muldiv_sbf_1_nxt,
  input  logic [XLEN:0]      muldiv_sbf_1_r
);

  typedef enum logic [2:0] {IDLE, EXEC, QCORR, RCORR, DONE} state_t;

  localparam logic [5:0] LAST_ITER = 6'(XLEN);

  state_t            state_q, state_d;
  logic [5:0]        cnt_q;
  logic [2:0]        op_q;
  logic [XLEN:0]     opa_q;
  logic              neg_q;
  logic [XLEN-1:0]   res_q;

  logic              accept;
  logic              in_div, in_sdiv, in_rem;
  logic              rs1_sgn_mul, rs2_sgn_mul;
  logic              rs1_neg, rs2_neg;
  logic [XLEN-1:0]   rs1_abs, rs2_abs;
  logic              div_by_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     corr_val;
  logic              res_load;
  logic [XLEN-1:0]   res_nxt;

  assign i_ready     = (state_q == IDLE) & ~flush;
  assign accept      = i_valid & i_ready & ~rst;
  assign busy        = (state_q != IDLE);
  assign o_valid     = (state_q == DONE);
  assign o_wbck_wdat = o_valid ? res_q : '0;

  // Request decode; division works on magnitudes and fixes signs at the end
  assign in_div      = i_op[2];
  assign in_sdiv     = ~i_op[0];
  assign in_rem      = i_op[1];
  assign rs1_sgn_mul = i_op[0] ^ i_op[1];
  assign rs2_sgn_mul = (i_op[1:0] == 2'b01);
  assign rs1_neg     = in_sdiv & i_rs1[XLEN-1];
  assign rs2_neg     = in_sdiv & i_rs2[XLEN-1];
  assign rs1_abs     = rs1_neg ? (~i_rs1 + 1'b1) : i_rs1;
  assign rs2_abs     = rs2_neg ? (~i_rs2 + 1'b1) : i_rs2;
  assign div_by_zero = (i_rs2 == '0);
  assign div_ovf     = in_sdiv & (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (i_rs2 == '1);
  assign special     = in_div & (div_by_zero | div_ovf);
  // Overflow quotient equals the dividend itself (most negative value)
  assign special_res = div_by_zero ? (in_rem ? i_rs1 : '1) : (in_rem ? '0 : i_rs1);
  assign corr_val    = op_q[1] ? muldiv_sbf_0_r : muldiv_sbf_1_r;

  always_comb begin
    state_d            = state_q;
    muldiv_req_alu     = 1'b0;
    muldiv_req_alu_op1 = '0;
    muldiv_req_alu_op2 = '0;
    muldiv_req_alu_add = 1'b0;
    muldiv_req_alu_sub = 1'b0;
    muldiv_sbf_0_ena   = 1'b0;
    muldiv_sbf_0_nxt   = '0;
    muldiv_sbf_1_ena   = 1'b0;
    muldiv_sbf_1_nxt   = '0;
    res_load           = 1'b0;
    res_nxt            = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          muldiv_sbf_0_ena = 1'b1;
          muldiv_sbf_1_ena = 1'b1;
          muldiv_sbf_1_nxt = in_div ? {1'b0, rs1_abs} : {rs2_sgn_mul & i_rs2[XLEN-1], i_rs2};
          if (special) begin
            state_d  = DONE;
            res_load = 1'b1;
            res_nxt  = special_res;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        muldiv_req_alu   = 1'b1;
        muldiv_sbf_0_ena = 1'b1;
        muldiv_sbf_1_ena = 1'b1;
        if (op_q[2]) begin
          // Non-restoring step: shift {R,Q} left, subtract if R>=0 else add
          muldiv_req_alu_op1 = {muldiv_sbf_0_r[XLEN], muldiv_sbf_0_r, muldiv_sbf_1_r[XLEN]};
          muldiv_req_alu_op2 = {2'b00, opa_q};
          muldiv_req_alu_sub = ~muldiv_sbf_0_r[XLEN];
          muldiv_req_alu_add = muldiv_sbf_0_r[XLEN];
          muldiv_sbf_0_nxt   = muldiv_req_alu_res[XLEN:0];
          muldiv_sbf_1_nxt   = {muldiv_sbf_1_r[XLEN-1:0], ~muldiv_req_alu_res[ADDER_W-1]};
        end else begin
          // Shift-add; the final step weights the multiplier sign bit negatively
          muldiv_req_alu_op1 = {{2{muldiv_sbf_0_r[XLEN]}}, muldiv_sbf_0_r};
          muldiv_req_alu_op2 = muldiv_sbf_1_r[0] ? {{2{opa_q[XLEN]}}, opa_q} : '0;
          if ((cnt_q == LAST_ITER) && muldiv_sbf_1_r[0]) muldiv_req_alu_sub = 1'b1;
          else                                           muldiv_req_alu_add = 1'b1;
          muldiv_sbf_0_nxt = muldiv_req_alu_res[XLEN+1:1];
          muldiv_sbf_1_nxt = {muldiv_req_alu_res[0], muldiv_sbf_1_r[XLEN:1]};
        end
        if (cnt_q == LAST_ITER) begin
          if (op_q[2]) begin
            state_d = QCORR;
          end else begin
            state_d  = DONE;
            res_load = 1'b1;
            res_nxt  = (op_q[1:0] == 2'b00) ? muldiv_sbf_1_r[XLEN:1]
                                            : muldiv_req_alu_res[XLEN-1:0];
          end
        end
      end
      QCORR: begin
        // Bring a negative partial remainder back into [0, divisor)
        muldiv_req_alu     = 1'b1;
        muldiv_req_alu_add = 1'b1;
        muldiv_req_alu_op1 = {{2{muldiv_sbf_0_r[XLEN]}}, muldiv_sbf_0_r};
        muldiv_req_alu_op2 = muldiv_sbf_0_r[XLEN] ? {2'b00, opa_q} : '0;
        muldiv_sbf_0_ena   = 1'b1;
        muldiv_sbf_0_nxt   = muldiv_req_alu_res[XLEN:0];
        state_d            = RCORR;
      end
      RCORR: begin
        muldiv_req_alu = 1'b1;
        if (neg_q) begin
          muldiv_req_alu_sub = 1'b1;
          muldiv_req_alu_op2 = {2'b00, corr_val};
        end else begin
          muldiv_req_alu_add = 1'b1;
          muldiv_req_alu_op1 = {2'b00, corr_val};
        end
        res_load = 1'b1;
        res_nxt  = muldiv_req_alu_res[XLEN-1:0];
        state_d  = DONE;
      end
      DONE: begin
        if (o_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opa_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= i_op;
        opa_q <= in_div ? {1'b0, rs2_abs} : {rs1_sgn_mul & i_rs1[XLEN-1], i_rs1};
        neg_q <= in_rem ? rs1_neg : (rs1_neg ^ rs2_neg);
        cnt_q <= '0;
      end else if (state_q == EXEC) begin
        cnt_q <= cnt_q + 6'd1;
      end
      if (res_load) res_q <= res_nxt;
    end
  end

endmodule

// File: tb/tb_e203_exu_muldiv_seq.sv
// Scoreboard bench for e203_exu_muldiv_seq with a behavioural model of the
// shared adder and state buffers.
module tb_e203_exu_muldiv_seq;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ready;
  logic [2:0]  i_op;
  logic [31:0] i_rs1, i_rs2;
  logic        flush;
  logic        o_valid, o_ready;
  logic [31:0] o_wbck_wdat;
  logic        busy;
  logic        muldiv_req_alu, muldiv_req_alu_add, muldiv_req_alu_sub;
  logic [34:0] muldiv_req_alu_op1, muldiv_req_alu_op2, muldiv_req_alu_res;
  logic        muldiv_sbf_0_ena, muldiv_sbf_1_ena;
  logic [32:0] muldiv_sbf_0_nxt, muldiv_sbf_0_r, muldiv_sbf_1_nxt, muldiv_sbf_1_r;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          alu_n;
    int          first;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   alu_cnt = 0;
  int   first_alu = -1;
  int   onehot_err = 0;
  int   zero_err = 0;
  logic prev_valid = 1'b0;

  e203_exu_muldiv_seq #(.XLEN(32), .ADDER_W(35)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .flush(flush),
    .o_valid(o_valid), .o_ready(o_ready), .o_wbck_wdat(o_wbck_wdat), .busy(busy),
    .muldiv_req_alu(muldiv_req_alu), .muldiv_req_alu_op1(muldiv_req_alu_op1),
    .muldiv_req_alu_op2(muldiv_req_alu_op2), .muldiv_req_alu_add(muldiv_req_alu_add),
    .muldiv_req_alu_sub(muldiv_req_alu_sub), .muldiv_req_alu_res(muldiv_req_alu_res),
    .muldiv_sbf_0_ena(muldiv_sbf_0_ena), .muldiv_sbf_0_nxt(muldiv_sbf_0_nxt),
    .muldiv_sbf_0_r(muldiv_sbf_0_r),
    .muldiv_sbf_1_ena(muldiv_sbf_1_ena), .muldiv_sbf_1_nxt(muldiv_sbf_1_nxt),
    .muldiv_sbf_1_r(muldiv_sbf_1_r)
  );

  always #5 clk = ~clk;

  // Datapath model: combinational adder plus the two state buffers
  always_comb begin
    muldiv_req_alu_res = '0;
    if (muldiv_req_alu_add)      muldiv_req_alu_res = muldiv_req_alu_op1 + muldiv_req_alu_op2;
    else if (muldiv_req_alu_sub) muldiv_req_alu_res = muldiv_req_alu_op1 - muldiv_req_alu_op2;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      muldiv_sbf_0_r <= '0;
      muldiv_sbf_1_r <= '0;
    end else begin
      if (muldiv_sbf_0_ena) muldiv_sbf_0_r <= muldiv_sbf_0_nxt;
      if (muldiv_sbf_1_ena) muldiv_sbf_1_r <= muldiv_sbf_1_nxt;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
  endtask

  // Monitor: pops an expectation at each rising o_valid
  always @(negedge clk) begin
    if (!rst) begin
      if (muldiv_req_alu) begin
        alu_cnt++;
        if (first_alu < 0) first_alu = cyc - acc_cyc;
        if (muldiv_req_alu_add == muldiv_req_alu_sub) onehot_err++;
      end else if (muldiv_req_alu_add || muldiv_req_alu_sub ||
                   muldiv_req_alu_op1 != '0 || muldiv_req_alu_op2 != '0) begin
        onehot_err++;
      end
      if (!o_valid && o_wbck_wdat != '0) zero_err++;
      if (o_valid && !prev_valid) begin
        checkOutput("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("result", o_wbck_wdat, e.data);
          checkOutput("latency", cyc - acc_cyc, e.lat);
          checkOutput("alu_cycles", alu_cnt, e.alu_n);
          checkOutput("alu_first", first_alu, e.first);
        end
      end
      if (i_valid && i_ready) begin
        acc_cyc   = cyc;
        alu_cnt   = 0;
        first_alu = -1;
      end
      prev_valid = o_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp, input int lat, input int alu_n,
                               input int first, input bit expect_result);
    int n = 0;
    if (expect_result) sb.push_back('{data: exp, lat: lat, alu_n: alu_n, first: first});
    i_op = op; i_rs1 = a; i_rs2 = b; i_valid = 1'b1;
    @(negedge clk);
    while (!i_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accepted", {31'b0, i_ready}, 32'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic waitHandshake();
    int n = 0;
    @(negedge clk);
    while (!(o_valid && o_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("handshake", {31'b0, o_valid && o_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input int alu_n, input int first);
    applyStimulus(op, a, b, exp, lat, alu_n, first, 1'b1);
    waitHandshake();
  endtask

  initial begin
    int n;
    rst = 1'b1; i_valid = 1'b0; i_op = '0; i_rs1 = '0; i_rs2 = '0; flush = 1'b0; o_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_i_ready", {31'b0, i_ready}, 32'd1);
    checkOutput("rst_o_valid", {31'b0, o_valid}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_wdat", o_wbck_wdat, 32'd0);
    checkOutput("rst_req_alu", {31'b0, muldiv_req_alu}, 32'd0);
    checkOutput("rst_sbf_ena", {30'b0, muldiv_sbf_0_ena, muldiv_sbf_1_ena}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    runOp(MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 33, 1);
    runOp(MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, 33, 1);
    runOp(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 33, 1);
    runOp(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 33, 1);
    runOp(MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34, 33, 1);
    runOp(DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 36, 35, 1);
    runOp(REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 36, 35, 1);
    runOp(DIVU,   32'd100,      32'd7,        32'd14,       36, 35, 1);
    runOp(REMU,   32'd100,      32'd7,        32'd2,        36, 35, 1);
    runOp(DIV,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 36, 35, 1);
    runOp(REM,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 36, 35, 1);
    runOp(DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1, 0, -1);
    runOp(REMU,   32'd5,        32'd0,        32'd5,        1, 0, -1);
    runOp(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, -1);
    runOp(REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0, -1);

    // Backpressure: result must hold while writeback stalls
    o_ready = 1'b0;
    applyStimulus(MUL, 32'd6, 32'd7, 32'd42, 34, 33, 1, 1'b1);
    n = 0;
    @(negedge clk);
    while (!o_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", {31'b0, o_valid}, 32'd1);
      checkOutput("bp_data", o_wbck_wdat, 32'd42);
      checkOutput("bp_i_ready", {31'b0, i_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    o_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("bp_i_ready_after", {31'b0, i_ready}, 32'd1);
    checkOutput("bp_valid_after", {31'b0, o_valid}, 32'd0);
    @(posedge clk); #1;

    // Flush at cycle 10 of a division, then a fresh multiply
    applyStimulus(DIV, 32'd100, 32'd7, 32'd0, 0, 0, 0, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_i_ready", {31'b0, i_ready}, 32'd1);
    checkOutput("flush_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    runOp(MUL, 32'd3, 32'd4, 32'd12, 34, 33, 1);

    // Reset in the middle of a multiply
    applyStimulus(MULHU, 32'd9, 32'd9, 32'd0, 0, 0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
    checkOutput("midrst_req_alu", {31'b0, muldiv_req_alu}, 32'd0);
    checkOutput("midrst_i_ready", {31'b0, i_ready}, 32'd1);
    @(posedge clk); #1;
    runOp(DIVU, 32'd1000, 32'd10, 32'd100, 36, 35, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("adder_port_rules", onehot_err, 32'd0);
    checkOutput("wdat_zero_when_idle", zero_err, 32'd0);
    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
